pwm_duty_sequencer: RTL and testbench
=====================================

Name: pwm_duty_sequencer

Overview:
- Soft-start/soft-stop controller that drives the 4-bit pulse_width input of the 500 Hz PWM generator from the 1 MHz clock domain.
- Accepts target duty commands over a valid/ready handshake.
- Ramps pulse_width one LSB at a time, changing it only at PWM period boundaries so no period is truncated mid-pulse.
- Provides an emergency stop that forces duty to zero immediately, and reports status to the supervising logic.

Parameters:
- PERIOD, 2000, clk_1MHz cycles per PWM period; must match the generator's full cycle.
- STEP_PERIODS, 4, whole PWM periods held at each intermediate duty step (1..255).
- PW_MAX, 15, maximum accepted target; larger targets are clamped.

Ports:
- clk_1MHz  input  1  system clock, 1 MHz.
- reset  input  1  synchronous, active-high reset.
- cmd_valid  input  1  target command present.
- cmd_target  input  4  requested pulse_width, 0..15.
- cmd_ready  output  1  command accepted this cycle when cmd_valid && cmd_ready.
- estop  input  1  level emergency stop.
- pulse_width  output  4  drives the generator's pulse_width.
- period_tick  output  1  one-cycle strobe on the last cycle of each PWM period.
- busy  output  1  ramp in progress.
- at_target  output  1  pulse_width equals the latched target and no ramp is pending.
- fault  output  1  sticky; set by estop.

Behaviour:
- Clock and reset: single clock domain; all state updates on posedge clk_1MHz. Reset is synchronous and active-high, sampled on the clock edge.
- Reset values:
  - pulse_width=0, target=0, period_cnt=0, dwell_cnt=0, state=IDLE.
  - cmd_ready=1, busy=0, at_target=1, fault=0, period_tick=0.
- Period counter:
  - 11-bit period_cnt counts 0..PERIOD-1, then wraps to 0.
  - period_tick is registered, so it asserts on the cycle where period_cnt==0 after a wrap; there is no tick on the first cycle after reset.
  - The counter runs in every state, including FAULT.
- FSM states: IDLE, RAMP_UP, RAMP_DOWN, FAULT.
- IDLE:
  - cmd_ready=1.
  - On an accepted command, latch target=min(cmd_target, PW_MAX) and clear dwell_cnt.
  - If target>pulse_width, go to RAMP_UP; if target<pulse_width, go to RAMP_DOWN; if equal, stay in IDLE (command consumed, no change).
- RAMP_UP / RAMP_DOWN:
  - cmd_ready=0 and busy=1; commands are held off.
  - At each period end (period_cnt==PERIOD-1): if dwell_cnt==STEP_PERIODS-1, step pulse_width by +1 or -1 and clear dwell_cnt; otherwise increment dwell_cnt.
  - The new pulse_width is visible on the cycle period_cnt==0.
  - When the stepped value equals target, return to IDLE in the same update.
- First step timing: the first step occurs at the STEP_PERIODS-th period end after acceptance, counting the partial period in which the command was accepted as one.
- Ramp duration: a full 0->15 ramp takes 15*STEP_PERIODS period ends.
- estop:
  - Any cycle with estop=1 (not in reset) forces pulse_width=0 on the next edge, regardless of period phase.
  - It also sets fault=1, moves to FAULT, sets target=0 and clears dwell_cnt.
- FAULT:
  - cmd_ready=0, busy=0, pulse_width held at 0.
  - Exit only via reset; estop deassertion alone does not clear FAULT.
- Simultaneous events:
  - estop beats an accepted command and beats a period-end step.
  - reset beats everything.
  - A command accepted on a period-end cycle starts its dwell on the following period (dwell_cnt=0 after that edge).
- Status flags:
  - at_target = (state==IDLE) && (pulse_width==target); it is 0 in FAULT.
  - busy = state is RAMP_UP or RAMP_DOWN.
- Reset mid-ramp: the ramp is abandoned; all outputs return to their reset values on the edge after reset is sampled.
- Arithmetic: pulse_width steps never wrap. It is bounded by target, which is always 0..PW_MAX.
- Output registering: all outputs are registered except cmd_ready, busy and at_target, which are decoded from registered state.

Test Plan:
- Reset, then observe 4001 cycles -> period_tick high at cycles 2000 and 4000 only; pulse_width=0; at_target=1; cmd_ready=1.
- Command target=3 accepted at cycle 10, STEP_PERIODS=4 -> pulse_width changes 0->1 at first period_cnt==0 after the 4th period end, then 2, then 3 every 4 periods (8000 cycles); returns to IDLE with at_target=1 and busy=0 after the last step.
- At pulse_width=3 in IDLE, command target=1 -> RAMP_DOWN; 3->2->1 at period boundaries only; cmd_valid during the ramp is held off (cmd_ready=0) and accepted once back in IDLE.
- Command target=15 then estop pulse for 1 cycle mid-period at pulse_width=6 -> pulse_width=0 on the next edge; fault=1; state FAULT.
  - Further commands are not accepted and fault stays 1 after estop drops.
  - reset clears fault and restores cmd_ready=1.
- Command accepted on the same cycle as estop -> estop wins; pulse_width stays 0, FAULT entered, target=0.
- reset asserted mid-RAMP_UP at pulse_width=5 -> next edge pulse_width=0, period_cnt=0, busy=0, at_target=1; a new command target=2 then ramps normally from 0.

Source files
------------

// File: rtl/pwm_duty_sequencer_if.sv
// Command, emergency-stop and status bundle between the supervisor and the duty sequencer.
interface pwm_duty_sequencer_if;
  logic       cmd_valid;
  logic [3:0] cmd_target;
  logic       cmd_ready;
  logic       estop;
  logic [3:0] pulse_width;
  logic       period_tick;
  logic       busy;
  logic       at_target;
  logic       fault;

  // Supervisor side: issues commands and estop, observes duty and status.
  modport master (
    output cmd_valid, cmd_target, estop,
    input  cmd_ready, pulse_width, period_tick, busy, at_target, fault
  );

  // Sequencer side.
  modport slave (
    input  cmd_valid, cmd_target, estop,
    output cmd_ready, pulse_width, period_tick, busy, at_target, fault
  );
endinterface

// File: rtl/pwm_duty_sequencer.sv
// Soft-start/soft-stop sequencer for the PWM generator's pulse_width: ramps one LSB
// per STEP_PERIODS periods, only at period boundaries, with a sticky emergency stop.
module pwm_duty_sequencer #(
  parameter int unsigned PERIOD       = 2000,
  parameter int unsigned STEP_PERIODS = 4,
  parameter int unsigned PW_MAX       = 15
) (
  input logic                 clk_1MHz,
  input logic                 reset,
  pwm_duty_sequencer_if.slave bus
);

  localparam int unsigned CNT_W   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int unsigned DWELL_W = 8;
  localparam int unsigned PW_W    = 4;

  localparam logic [CNT_W-1:0]   PERIOD_LAST = CNT_W'(PERIOD - 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST  = DWELL_W'(STEP_PERIODS - 1);
  localparam logic [PW_W-1:0]    PW_CEIL     = PW_W'(PW_MAX);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2,
    FAULT     = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   period_cnt_q;
  logic               period_tick_q;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [PW_W-1:0]    pw_q, pw_d;
  logic [PW_W-1:0]    target_q, target_d;
  logic               fault_q, fault_d;

  logic               period_end_c;
  logic               cmd_fire_c;
  logic [PW_W-1:0]    cmd_clamped_c;
  logic [PW_W-1:0]    pw_stepped_c;

  assign period_end_c  = (period_cnt_q == PERIOD_LAST);
  assign cmd_fire_c    = bus.cmd_valid && (state_q == IDLE);
  assign cmd_clamped_c = (bus.cmd_target > PW_CEIL) ? PW_CEIL : bus.cmd_target;
  assign pw_stepped_c  = (state_q == RAMP_UP) ? (pw_q + PW_W'(1)) : (pw_q - PW_W'(1));

  // Free-running period phase; keeps counting through FAULT so ticks stay aligned.
  always_ff @(posedge clk_1MHz) begin
    if (reset) begin
      period_cnt_q  <= '0;
      period_tick_q <= 1'b0;
    end else begin
      period_tick_q <= period_end_c;
      period_cnt_q  <= period_end_c ? '0 : (period_cnt_q + CNT_W'(1));
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_1MHz) begin
    if (reset) begin
      state_q  <= IDLE;
      dwell_q  <= '0;
      pw_q     <= '0;
      target_q <= '0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      dwell_q  <= dwell_d;
      pw_q     <= pw_d;
      target_q <= target_d;
      fault_q  <= fault_d;
    end
  end

  // Next-state and datapath update; estop is applied last so it overrides everything.
  always_comb begin
    state_d  = state_q;
    dwell_d  = dwell_q;
    pw_d     = pw_q;
    target_d = target_q;
    fault_d  = fault_q;

    case (state_q)
      IDLE: begin
        if (cmd_fire_c) begin
          target_d = cmd_clamped_c;
          dwell_d  = '0;
          if (cmd_clamped_c > pw_q) begin
            state_d = RAMP_UP;
          end else if (cmd_clamped_c < pw_q) begin
            state_d = RAMP_DOWN;
          end
        end
      end

      RAMP_UP, RAMP_DOWN: begin
        // Duty only moves on the last cycle of a period, so no pulse is cut short.
        if (period_end_c) begin
          if (dwell_q == DWELL_LAST) begin
            pw_d    = pw_stepped_c;
            dwell_d = '0;
            if (pw_stepped_c == target_q) begin
              state_d = IDLE;
            end
          end else begin
            dwell_d = dwell_q + DWELL_W'(1);
          end
        end
      end

      FAULT: begin
        pw_d = '0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (bus.estop) begin
      state_d  = FAULT;
      pw_d     = '0;
      target_d = '0;
      dwell_d  = '0;
      fault_d  = 1'b1;
    end
  end

  assign bus.pulse_width = pw_q;
  assign bus.period_tick = period_tick_q;
  assign bus.fault       = fault_q;
  assign bus.cmd_ready   = (state_q == IDLE);
  assign bus.busy        = (state_q == RAMP_UP) || (state_q == RAMP_DOWN);
  assign bus.at_target   = (state_q == IDLE) && (pw_q == target_q);

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Directed bench for pwm_duty_sequencer: expected duty changes are queued when a command
// or estop is issued and matched against duty changes seen on the DUT.
module tb_pwm_duty_sequencer;

  // Shortened period keeps the long ramps affordable; timing is derived from it.
  localparam int unsigned PERIOD = 500;
  localparam int unsigned STEP   = 4;
  localparam int unsigned PW_MAX = 15;

  typedef struct packed {
    logic [31:0] cyc;
    logic [3:0]  pw;
  } evt_t;

  logic        clk_1MHz = 1'b0;
  logic        reset;
  logic [31:0] cyc;
  logic [3:0]  last_pw = 4'd0;
  logic        mon_en  = 1'b0;
  evt_t        mon_e;
  evt_t        exp_q[$];
  evt_t        obs_q[$];
  int unsigned checks  = 0;
  int unsigned errors  = 0;

  pwm_duty_sequencer_if bus ();

  pwm_duty_sequencer #(
    .PERIOD      (PERIOD),
    .STEP_PERIODS(STEP),
    .PW_MAX      (PW_MAX)
  ) dut (
    .clk_1MHz(clk_1MHz),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clk_1MHz = ~clk_1MHz;

  // Cycle index since the last reset; equals the period phase modulo PERIOD.
  always_ff @(posedge clk_1MHz) begin
    if (reset) cyc <= 32'd0;
    else       cyc <= cyc + 32'd1;
  end

  // Record every observed duty change with the cycle it first appears on.
  always @(negedge clk_1MHz) begin
    if (mon_en && (bus.pulse_width !== last_pw)) begin
      mon_e.cyc = cyc;
      mon_e.pw  = bus.pulse_width;
      obs_q.push_back(mon_e);
    end
    last_pw = bus.pulse_width;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Queue the duty changes a ramp from 'from' should produce until it reaches 'upto'.
  task automatic push_ramp(input logic [31:0] acc, input logic [3:0] from, input logic [3:0] upto);
    logic [31:0] first_end;
    logic [3:0]  pw;
    evt_t        e;
    first_end = (acc / PERIOD) * PERIOD + PERIOD - 1;
    if (first_end == acc) first_end = first_end + PERIOD;
    pw = from;
    for (int i = 1; pw != upto; i++) begin
      pw    = (upto > pw) ? (pw + 4'd1) : (pw - 4'd1);
      e.cyc = first_end + (32'(i) * STEP - 1) * PERIOD + 1;
      e.pw  = pw;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_drain(input string tag);
    int unsigned n;
    int unsigned budget;
    evt_t        e;
    evt_t        o;
    n      = 0;
    budget = (32'(exp_q.size()) * STEP + 2) * PERIOD;
    while ((obs_q.size() < exp_q.size()) && (n < budget)) begin
      @(negedge clk_1MHz);
      n++;
    end
    check({tag, " change count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front();
      else                  o = '1;
      check({tag, " change cycle"}, o.cyc, e.cyc);
      check({tag, " change value"}, 32'(o.pw), 32'(e.pw));
    end
    obs_q.delete();
  endtask

  // Present a command at a negedge and hold it until accepted; returns the accept cycle.
  task automatic send(input logic [3:0] t, output logic [31:0] acc);
    int unsigned n;
    n              = 0;
    bus.cmd_valid  = 1'b1;
    bus.cmd_target = t;
    while (!bus.cmd_ready && (n < 8 * STEP * PERIOD)) begin
      @(negedge clk_1MHz);
      n++;
    end
    check("cmd_ready at accept", 32'(bus.cmd_ready), 32'd1);
    acc = cyc;
    @(negedge clk_1MHz);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk_1MHz);
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] acc;
    logic [31:0] acc2;
    logic [31:0] s;
    int unsigned bad;
    int unsigned nticks;

    reset          = 1'b1;
    bus.cmd_valid  = 1'b0;
    bus.cmd_target = 4'd0;
    bus.estop      = 1'b0;
    repeat (3) @(negedge clk_1MHz);
    reset = 1'b0;

    // Reset state and idle period ticks.
    check("reset pulse_width", 32'(bus.pulse_width), 32'd0);
    check("reset at_target",   32'(bus.at_target),   32'd1);
    check("reset cmd_ready",   32'(bus.cmd_ready),   32'd1);
    check("reset busy",        32'(bus.busy),        32'd0);
    check("reset fault",       32'(bus.fault),       32'd0);
    check("reset period_tick", 32'(bus.period_tick), 32'd0);
    mon_en = 1'b1;
    bad    = 0;
    nticks = 0;
    for (int i = 0; i <= 2 * int'(PERIOD); i++) begin
      if (bus.period_tick === 1'b1) nticks++;
      if (bus.period_tick !== ((cyc != 0) && (cyc % PERIOD == 0))) bad++;
      @(negedge clk_1MHz);
    end
    check("tick misplaced cycles", bad, 0);
    check("tick count", nticks, 2);
    check("idle duty changes", 32'(obs_q.size()), 32'd0);

    // Ramp up 0->3 from a command accepted at period phase 10.
    while ((cyc % PERIOD) != 10) @(negedge clk_1MHz);
    send(4'd3, acc);
    check("ramp busy",      32'(bus.busy),      32'd1);
    check("ramp cmd_ready", 32'(bus.cmd_ready), 32'd0);
    check("ramp at_target", 32'(bus.at_target), 32'd0);
    push_ramp(acc, 4'd0, 4'd3);
    wait_drain("up 0->3");
    check("up done at_target", 32'(bus.at_target), 32'd1);
    check("up done busy",      32'(bus.busy),      32'd0);
    check("up done cmd_ready", 32'(bus.cmd_ready), 32'd1);

    // Ramp down 3->1 with a second command held off until IDLE.
    send(4'd1, acc);
    push_ramp(acc, 4'd3, 4'd1);
    s              = exp_q[$].cyc;
    bus.cmd_valid  = 1'b1;
    bus.cmd_target = 4'd2;
    @(negedge clk_1MHz);
    check("held cmd_ready", 32'(bus.cmd_ready), 32'd0);
    send(4'd2, acc2);
    check("held cmd accept cycle", acc2, s);
    wait_drain("down 3->1");
    push_ramp(acc2, 4'd1, 4'd2);
    wait_drain("up 1->2");
    check("1->2 at_target", 32'(bus.at_target), 32'd1);

    // Target 15 interrupted by a one-cycle estop mid-period at duty 6.
    send(4'd15, acc);
    push_ramp(acc, 4'd2, 4'd6);
    wait_drain("up 2->6");
    repeat (PERIOD / 2) @(negedge clk_1MHz);
    bus.estop = 1'b1;
    mon_e.cyc = cyc + 32'd1;
    mon_e.pw  = 4'd0;
    exp_q.push_back(mon_e);
    @(negedge clk_1MHz);
    bus.estop = 1'b0;
    check("estop pulse_width", 32'(bus.pulse_width), 32'd0);
    check("estop fault",       32'(bus.fault),       32'd1);
    check("estop busy",        32'(bus.busy),        32'd0);
    check("estop cmd_ready",   32'(bus.cmd_ready),   32'd0);
    check("estop at_target",   32'(bus.at_target),   32'd0);
    wait_drain("estop");
    bus.cmd_valid  = 1'b1;
    bus.cmd_target = 4'd5;
    bad            = 0;
    repeat (2 * PERIOD) begin
      @(negedge clk_1MHz);
      if ((bus.cmd_ready !== 1'b0) || (bus.pulse_width !== 4'd0) || (bus.fault !== 1'b1)) bad++;
    end
    bus.cmd_valid = 1'b0;
    check("fault hold violations", bad, 0);
    check("fault duty changes", 32'(obs_q.size()), 32'd0);
    pulse_reset();
    check("clear fault",     32'(bus.fault),     32'd0);
    check("clear cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("clear at_target", 32'(bus.at_target), 32'd1);

    // Command and estop on the same cycle: estop wins.
    bus.cmd_valid  = 1'b1;
    bus.cmd_target = 4'd9;
    bus.estop      = 1'b1;
    @(negedge clk_1MHz);
    bus.cmd_valid = 1'b0;
    bus.estop     = 1'b0;
    check("race fault",       32'(bus.fault),       32'd1);
    check("race busy",        32'(bus.busy),        32'd0);
    check("race pulse_width", 32'(bus.pulse_width), 32'd0);
    check("race at_target",   32'(bus.at_target),   32'd0);
    repeat (2 * PERIOD) @(negedge clk_1MHz);
    check("race duty changes", 32'(obs_q.size()), 32'd0);
    pulse_reset();

    // Reset mid-ramp at duty 5, then a fresh ramp from 0.
    send(4'd9, acc);
    push_ramp(acc, 4'd0, 4'd5);
    wait_drain("up 0->5");
    repeat (PERIOD / 3) @(negedge clk_1MHz);
    check("pre-reset busy", 32'(bus.busy), 32'd1);
    mon_en = 1'b0;
    pulse_reset();
    check("mid reset pulse_width", 32'(bus.pulse_width), 32'd0);
    check("mid reset busy",        32'(bus.busy),        32'd0);
    check("mid reset at_target",   32'(bus.at_target),   32'd1);
    check("mid reset cmd_ready",   32'(bus.cmd_ready),   32'd1);
    check("mid reset period_tick", 32'(bus.period_tick), 32'd0);
    @(negedge clk_1MHz);
    mon_en = 1'b1;
    send(4'd2, acc);
    push_ramp(acc, 4'd0, 4'd2);
    wait_drain("after reset 0->2");
    check("after reset at_target", 32'(bus.at_target), 32'd1);
    check("after reset busy",      32'(bus.busy),      32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
